lock_response_checker: RTL and testbench

- Synthesizable response-side companion to the locked 16-bit carry-lookahead adder stimulus flow.
- Accepts each applied operand pair together with the locked adder's 17-bit result and recomputes the golden sum internally.
- Per key trial, accumulates three figures of merit: corrupted-vector count, total Hamming distance and worst-case per-vector Hamming distance.
- Sits beside the locked adder in on-chip key-sweep harnesses; replaces text-log post-processing of $monitor output.

---
 rtl/lock_response_checker.sv | 198 +++++++++++++++++++
 tb/tb_lock_response_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_response_checker.sv
// Response checker for the locked 16-bit adder. It recomputes the golden sum and counts corrupted vectors, total and worst Hamming distance per key trial.
// Optional capture of the first failing vector: define LOCK_CHK_FIRST_FAIL_EN.
module lock_response_checker #(
  parameter int NUM_VECTORS = 5000,
  parameter int CNT_W       = 13,
  parameter int HAM_W       = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      key_i,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  input  logic [15:0]      add1_i,
  input  logic [15:0]      add2_i,
  input  logic [16:0]      locked_res_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      key_o,
  output logic [CNT_W-1:0] err_vec_cnt_o,
  output logic [HAM_W-1:0] ham_sum_o,
  output logic [4:0]       max_ham_o
`ifdef LOCK_CHK_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld_o,
  output logic [CNT_W-1:0] first_fail_idx_o,
  output logic [15:0]      first_fail_a_o,
  output logic [15:0]      first_fail_b_o,
  output logic [16:0]      first_fail_res_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] NUM_V    = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] acc_cnt_reg;
  logic [31:0]      key_reg;
  logic [CNT_W-1:0] err_reg;
  logic [HAM_W-1:0] ham_reg;
  logic [4:0]       max_reg;
  logic             done_reg;

  logic             s1_vld_reg;
  logic [16:0]      s1_diff_reg;
  logic             s2_vld_reg;
  logic [4:0]       s2_pop_reg;

  logic             ready_int;
  logic             accept;
  logic             start_ok;
  logic             pipe_empty;
  logic [16:0]      golden;
  logic [4:0]       pop_next;
  logic [HAM_W:0]   ham_wide;
  logic [HAM_W-1:0] ham_sat;

  assign ready_int  = (state_reg == RUN) && (acc_cnt_reg < NUM_V);
  assign accept     = vec_valid_i && ready_int;
  assign start_ok   = start_i && ((state_reg == IDLE) || (state_reg == DONE));
  assign pipe_empty = !s1_vld_reg && !s2_vld_reg;
  assign golden     = {1'b0, add1_i} + {1'b0, add2_i};

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < 17; i++) begin
      pop_next = pop_next + {4'd0, s1_diff_reg[i]};
    end
  end

  // Hamming sum pins at all-ones instead of wrapping.
  assign ham_wide = {1'b0, ham_reg} + {{(HAM_W - 4){1'b0}}, s2_pop_reg};
  assign ham_sat  = ham_wide[HAM_W] ? {HAM_W{1'b1}} : ham_wide[HAM_W-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (accept && (acc_cnt_reg == LAST_IDX)) state_next = DRAIN;
      DRAIN:   if (pipe_empty) state_next = DONE;
      DONE:    if (start_i) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_cnt_reg <= '0;
      key_reg     <= '0;
      err_reg     <= '0;
      ham_reg     <= '0;
      max_reg     <= '0;
      done_reg    <= 1'b0;
      s1_vld_reg  <= 1'b0;
      s1_diff_reg <= '0;
      s2_vld_reg  <= 1'b0;
      s2_pop_reg  <= '0;
    end else begin
      done_reg   <= (state_reg == DRAIN) && pipe_empty;
      s1_vld_reg <= accept;
      if (accept) s1_diff_reg <= locked_res_i ^ golden;
      s2_vld_reg <= s1_vld_reg;
      if (s1_vld_reg) s2_pop_reg <= pop_next;

      // The pipeline is always empty in IDLE/DONE, so a start never races an update.
      if (start_ok) begin
        key_reg     <= key_i;
        acc_cnt_reg <= '0;
        err_reg     <= '0;
        ham_reg     <= '0;
        max_reg     <= '0;
      end else begin
        if (accept) acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
        if (s2_vld_reg) begin
          if (s2_pop_reg != 5'd0) err_reg <= err_reg + CNT_W'(1);
          ham_reg <= ham_sat;
          if (s2_pop_reg > max_reg) max_reg <= s2_pop_reg;
        end
      end
    end
  end

  assign vec_ready_o   = ready_int;
  assign busy_o        = (state_reg == RUN) || (state_reg == DRAIN);
  assign done_o        = done_reg;
  assign key_o         = key_reg;
  assign err_vec_cnt_o = err_reg;
  assign ham_sum_o     = ham_reg;
  assign max_ham_o     = max_reg;

`ifdef LOCK_CHK_FIRST_FAIL_EN
  logic [CNT_W-1:0] s1_idx_reg, s2_idx_reg;
  logic [15:0]      s1_a_reg, s2_a_reg, s1_b_reg, s2_b_reg;
  logic [16:0]      s1_res_reg, s2_res_reg;
  logic             ff_vld_reg;
  logic [CNT_W-1:0] ff_idx_reg;
  logic [15:0]      ff_a_reg, ff_b_reg;
  logic [16:0]      ff_res_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_idx_reg <= '0;
      s1_a_reg   <= '0;
      s1_b_reg   <= '0;
      s1_res_reg <= '0;
      s2_idx_reg <= '0;
      s2_a_reg   <= '0;
      s2_b_reg   <= '0;
      s2_res_reg <= '0;
      ff_vld_reg <= 1'b0;
      ff_idx_reg <= '0;
      ff_a_reg   <= '0;
      ff_b_reg   <= '0;
      ff_res_reg <= '0;
    end else begin
      if (accept) begin
        s1_idx_reg <= acc_cnt_reg;
        s1_a_reg   <= add1_i;
        s1_b_reg   <= add2_i;
        s1_res_reg <= locked_res_i;
      end
      if (s1_vld_reg) begin
        s2_idx_reg <= s1_idx_reg;
        s2_a_reg   <= s1_a_reg;
        s2_b_reg   <= s1_b_reg;
        s2_res_reg <= s1_res_reg;
      end
      if (start_ok) begin
        ff_vld_reg <= 1'b0;
        ff_idx_reg <= '0;
        ff_a_reg   <= '0;
        ff_b_reg   <= '0;
        ff_res_reg <= '0;
      end else if (s2_vld_reg && (s2_pop_reg != 5'd0) && !ff_vld_reg) begin
        ff_vld_reg <= 1'b1;
        ff_idx_reg <= s2_idx_reg;
        ff_a_reg   <= s2_a_reg;
        ff_b_reg   <= s2_b_reg;
        ff_res_reg <= s2_res_reg;
      end
    end
  end

  assign first_fail_vld_o = ff_vld_reg;
  assign first_fail_idx_o = ff_idx_reg;
  assign first_fail_a_o   = ff_a_reg;
  assign first_fail_b_o   = ff_b_reg;
  assign first_fail_res_o = ff_res_reg;
`endif

endmodule

// File: tb/tb_lock_response_checker.sv
// Scoreboard bench for lock_response_checker with a 4-vector trial. Expected
// trial results are queued at start and popped on done_o.
module tb_lock_response_checker;
  localparam int NV    = 4;
  localparam int CNT_W = 13;
  localparam int HAM_W = 17;

  logic             clk = 1'b0;
  logic             rst_i, start_i, vec_valid_i;
  logic [31:0]      key_i;
  logic [15:0]      add1_i, add2_i;
  logic [16:0]      locked_res_i;
  logic             vec_ready_o, busy_o, done_o;
  logic [31:0]      key_o;
  logic [CNT_W-1:0] err_vec_cnt_o;
  logic [HAM_W-1:0] ham_sum_o;
  logic [4:0]       max_ham_o;
`ifdef LOCK_CHK_FIRST_FAIL_EN
  logic             first_fail_vld_o;
  logic [CNT_W-1:0] first_fail_idx_o;
  logic [15:0]      first_fail_a_o, first_fail_b_o;
  logic [16:0]      first_fail_res_o;
`endif

  lock_response_checker #(.NUM_VECTORS(NV), .CNT_W(CNT_W), .HAM_W(HAM_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .key_i(key_i),
    .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o),
    .add1_i(add1_i), .add2_i(add2_i), .locked_res_i(locked_res_i),
    .busy_o(busy_o), .done_o(done_o), .key_o(key_o),
    .err_vec_cnt_o(err_vec_cnt_o), .ham_sum_o(ham_sum_o), .max_ham_o(max_ham_o)
`ifdef LOCK_CHK_FIRST_FAIL_EN
    , .first_fail_vld_o(first_fail_vld_o), .first_fail_idx_o(first_fail_idx_o),
    .first_fail_a_o(first_fail_a_o), .first_fail_b_o(first_fail_b_o),
    .first_fail_res_o(first_fail_res_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      key;
    logic [CNT_W-1:0] err;
    logic [HAM_W-1:0] ham;
    logic [4:0]       mx;
    logic             ffv;
    logic [CNT_W-1:0] ffi;
    logic [15:0]      ffa;
    logic [15:0]      ffb;
    logic [16:0]      ffr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   done_cnt = 0;

  logic [15:0] tab_a [NV] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234};
  logic [15:0] tab_b [NV] = '{16'h0002, 16'h0001, 16'h8000, 16'h4321};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every done_o pulse must match the oldest queued trial.
  always @(negedge clk) begin
    if (done_o) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("trial key=%08h err=%0d ham=%0d max=%0d (exp %0d/%0d/%0d)",
                 key_o, err_vec_cnt_o, ham_sum_o, max_ham_o, e.err, e.ham, e.mx);
        check("key_o", 64'(key_o), 64'(e.key));
        check("err_vec_cnt", 64'(err_vec_cnt_o), 64'(e.err));
        check("ham_sum", 64'(ham_sum_o), 64'(e.ham));
        check("max_ham", 64'(max_ham_o), 64'(e.mx));
`ifdef LOCK_CHK_FIRST_FAIL_EN
        check("ff_vld", 64'(first_fail_vld_o), 64'(e.ffv));
        check("ff_idx", 64'(first_fail_idx_o), 64'(e.ffi));
        check("ff_a", 64'(first_fail_a_o), 64'(e.ffa));
        check("ff_b", 64'(first_fail_b_o), 64'(e.ffb));
        check("ff_res", 64'(first_fail_res_o), 64'(e.ffr));
`endif
      end
    end
  end

  // mode 0 exact, 1 LSB flipped, 2 carry-out lost on pair 1, 3 fully inverted
  function automatic logic [16:0] res_for(input int mode, input int i);
    logic [16:0] g;
    g = {1'b0, tab_a[i]} + {1'b0, tab_b[i]};
    case (mode)
      1:       return g ^ 17'h00001;
      2:       return (i == 1) ? 17'h00000 : g;
      3:       return ~g;
      default: return g;
    endcase
  endfunction

  task automatic push_expected(input logic [31:0] key, input int mode);
    exp_t e;
    e = '{key: key, err: '0, ham: '0, mx: '0, ffv: 1'b0, ffi: '0, ffa: '0, ffb: '0, ffr: '0};
    for (int i = 0; i < NV; i++) begin
      logic [16:0] g, r;
      int p;
      g = {1'b0, tab_a[i]} + {1'b0, tab_b[i]};
      r = res_for(mode, i);
      p = $countones(r ^ g);
      if (p != 0) begin
        e.err = e.err + 1'b1;
        e.ham = e.ham + HAM_W'(p);
        if (p > int'(e.mx)) e.mx = 5'(p);
        if (!e.ffv) begin
          e.ffv = 1'b1; e.ffi = CNT_W'(i); e.ffa = tab_a[i]; e.ffb = tab_b[i]; e.ffr = r;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic do_start(input logic [31:0] key);
    start_i = 1'b1;
    key_i   = key;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("start_busy", 64'(busy_o), 64'd1);
    check("start_ready", 64'(vec_ready_o), 64'd1);
    check("start_done_low", 64'(done_o), 64'd0);
    check("start_err_clr", 64'(err_vec_cnt_o), 64'd0);
    check("start_ham_clr", 64'(ham_sum_o), 64'd0);
    check("start_max_clr", 64'(max_ham_o), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r);
    logic rdy;
    int k;
    vec_valid_i = 1'b1; add1_i = a; add2_i = b; locked_res_i = r;
    k = 0;
    do begin
      @(negedge clk);
      rdy = vec_ready_o;
      @(posedge clk); #1;
      k++;
    end while (!rdy && k < 20);
    if (!rdy) check("accept_timeout", 64'd0, 64'd1);
    vec_valid_i = 1'b0;
  endtask

  task automatic run_trial(input logic [31:0] key, input int mode, input bit gaps, input bit mid_start);
    int lat;
    push_expected(key, mode);
    do_start(key);
    for (int i = 0; i < NV; i++) begin
      if (mid_start && i == 2) begin
        start_i = 1'b1;
        key_i   = 32'hD7D41D03;
      end
      send_pair(tab_a[i], tab_b[i], res_for(mode, i));
      start_i = 1'b0;
      if (gaps && i < NV - 1) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("ready_drop", 64'(vec_ready_o), 64'd0);
    lat = 1;
    while (!done_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", 64'(done_o), 64'd1);
    check("done_latency_3to4", 64'((lat - 1) >= 3 && (lat - 1) <= 4), 64'd1);
    check("busy_in_done", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int d0;
    rst_i = 1'b1; start_i = 1'b0; key_i = '0; vec_valid_i = 1'b0;
    add1_i = '0; add2_i = '0; locked_res_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(vec_ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_key", 64'(key_o), 64'd0);
    check("rst_err", 64'(err_vec_cnt_o), 64'd0);
    check("rst_ham", 64'(ham_sum_o), 64'd0);
    check("rst_max", 64'(max_ham_o), 64'd0);

    run_trial(32'hD7D41D23, 0, 1'b0, 1'b0);
    run_trial(32'hD7D41D23, 1, 1'b0, 1'b1);
    run_trial(32'hA5A50001, 2, 1'b0, 1'b0);
    run_trial(32'h0BADF00D, 3, 1'b1, 1'b0);
    run_trial(32'h12345678, 1, 1'b1, 1'b0);

    // abort mid-trial: no expectation queued, so any done_o is flagged
    do_start(32'hCAFEBABE);
    send_pair(tab_a[0], tab_b[0], res_for(3, 0));
    send_pair(tab_a[1], tab_b[1], res_for(3, 1));
    rst_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_ready", 64'(vec_ready_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_key", 64'(key_o), 64'd0);
    check("abort_err", 64'(err_vec_cnt_o), 64'd0);
    check("abort_ham", 64'(ham_sum_o), 64'd0);
    check("abort_max", 64'(max_ham_o), 64'd0);
    rst_i = 1'b0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    check("abort_still_idle", 64'(busy_o), 64'd0);
    @(posedge clk); #1;

    run_trial(32'hD7D41D23, 3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
